shifter_pipe_n: RTL and testbench

Parametrised, pipelined barrel shifter. It generalises the fixed 32-bit shift-by-2 L/R/NO stage into a full log2(WIDTH)-stage shifter. Shift amount is any value 0..WIDTH-1, with four modes (logical left, logical right, arithmetic right, rotate right). A valid/ready handshake with backpressure lets it sit between datapath pipeline registers in the ALU/execute path.

---
 rtl/shifter_pipe_n_if.sv | 45 ++++
 rtl/shifter_pipe_n.sv | 123 ++++++++++++
 tb/tb_shifter_pipe_n.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pipe_n_if.sv
// -----------------------------------------------------------------------------
// shifter_pipe_n_if
// Purpose : bundles the upstream (operation) and downstream (result) handshake
//           of the pipelined barrel shifter into one interface.
// Signals :
//   in_valid / in_ready   upstream handshake
//   in_data  [WIDTH]      operand
//   amt      [LOG2W]      shift amount 0..WIDTH-1
//   mode     [2]          00 LSL, 01 LSR, 10 ASR, 11 ROR
//   tag      [TAG_W]      opaque sideband carried with the operation
//   out_valid / out_ready downstream handshake
//   out_data [WIDTH]      shifted result
//   out_tag  [TAG_W]      tag belonging to out_data
//   out_zero              high when out_data == 0
// Modports: master = producer/consumer side (testbench, surrounding datapath),
//           slave  = the shifter itself.
// -----------------------------------------------------------------------------
interface shifter_pipe_n_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int LOG2W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] amt;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, amt, mode, tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, amt, mode, tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/shifter_pipe_n.sv
// -----------------------------------------------------------------------------
// shifter_pipe_n
// Purpose : parametrised, pipelined barrel shifter with valid/ready flow
//           control. LOG2W stages; stage k shifts by 2^k when the current
//           amount bit is set. Modes: LSL, LSR, ASR, ROR.
// Ports   :
//   i_clk   rising-edge clock
//   i_rst   asynchronous, active-high reset; drops every in-flight entry
//   bus     shifter_pipe_n_if.slave (operation in, result out, see interface)
// Latency : LOG2W cycles, one operation per cycle, LOG2W entries of buffering.
// -----------------------------------------------------------------------------
module shifter_pipe_n #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  shifter_pipe_n_if.slave    bus
);
  localparam int LOG2W = $clog2(WIDTH);

  // Source of each stage: index 0 is the upstream port, index k>0 is stage k-1.
  logic [LOG2W-1:0]                w_src_valid;
  logic [LOG2W-1:0][WIDTH-1:0]     w_src_data;
  logic [LOG2W-1:0][LOG2W-1:0]     w_src_amt;
  logic [LOG2W-1:0][1:0]           w_src_mode;
  logic [LOG2W-1:0][TAG_W-1:0]     w_src_tag;

  logic [LOG2W-1:0]                w_valid;  // occupancy of every stage
  logic [LOG2W:0]                  w_load;   // load enable; [LOG2W] = downstream

  assign w_src_valid[0] = bus.in_valid;
  assign w_src_data[0]  = bus.in_data;
  assign w_src_amt[0]   = bus.amt;
  assign w_src_mode[0]  = bus.mode;
  assign w_src_tag[0]   = bus.tag;

  // A stage loads when it is empty or its successor loads this cycle, so
  // bubbles collapse during a stall while held entries stay put.
  always_comb begin
    w_load         = '0;
    w_load[LOG2W]  = bus.out_ready;
    for (int k = LOG2W - 1; k >= 0; k--) begin
      w_load[k] = ~w_valid[k] | w_load[k+1];
    end
  end

  assign bus.in_ready = w_load[0];

  for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
    localparam int SHIFT = 1 << gi;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] w_shifted;

    // The amount is shifted down one bit per stage, so bit 0 is always the
    // decision bit for the stage that sees it.
    always_comb begin
      w_shifted = w_src_data[gi];
      if (w_src_amt[gi][0]) begin
        case (w_src_mode[gi])
          2'b00:   w_shifted = w_src_data[gi] << SHIFT;
          2'b01:   w_shifted = w_src_data[gi] >> SHIFT;
          // Earlier ASR stages keep the MSB, so the local MSB is the sign.
          2'b10:   w_shifted = $signed(w_src_data[gi]) >>> SHIFT;
          default: w_shifted = (w_src_data[gi] >> SHIFT) |
                               (w_src_data[gi] << (WIDTH - SHIFT));
        endcase
      end
    end

    // Payload only moves with a valid entry, so undriven operands on idle
    // cycles never reach the registers and never touch a valid bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_load[gi]) begin
        r_valid <= w_src_valid[gi];
        if (w_src_valid[gi]) begin
          r_data <= w_shifted;
          r_tag  <= w_src_tag[gi];
        end
      end
    end

    assign w_valid[gi] = r_valid;

    if (gi < LOG2W - 1) begin : g_fwd
      logic [LOG2W-1:0] r_amt;
      logic [1:0]       r_mode;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_amt  <= '0;
          r_mode <= '0;
        end else if (w_load[gi] && w_src_valid[gi]) begin
          r_amt  <= w_src_amt[gi] >> 1;
          r_mode <= w_src_mode[gi];
        end
      end

      assign w_src_valid[gi+1] = r_valid;
      assign w_src_data[gi+1]  = r_data;
      assign w_src_amt[gi+1]   = r_amt;
      assign w_src_mode[gi+1]  = r_mode;
      assign w_src_tag[gi+1]   = r_tag;
    end else begin : g_last
      assign bus.out_valid = r_valid;
      assign bus.out_data  = r_data;
      assign bus.out_tag   = r_tag;
      assign bus.out_zero  = ~|r_data;
    end
  end

  // The last stage only consumes bit 0 of its remaining amount; the upper
  // bits are always zero by then.
  logic w_unused_amt_hi;
  assign w_unused_amt_hi = ^w_src_amt[LOG2W-1][LOG2W-1:1];
endmodule

// File: tb/tb_shifter_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_shifter_pipe_n
// Directed bench for shifter_pipe_n at WIDTH=32 (main), 8 and 64.
// -----------------------------------------------------------------------------
module tb_shifter_pipe_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shifter_pipe_n_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  shifter_pipe_n_if #(.WIDTH(8),  .TAG_W(2)) b8  ();
  shifter_pipe_n_if #(.WIDTH(64), .TAG_W(4)) b64 ();

  shifter_pipe_n #(.WIDTH(32), .TAG_W(4)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
  shifter_pipe_n #(.WIDTH(8),  .TAG_W(2)) dut8  (.i_clk(clk), .i_rst(rst), .bus(b8));
  shifter_pipe_n #(.WIDTH(64), .TAG_W(4)) dut64 (.i_clk(clk), .i_rst(rst), .bus(b64));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [63:0] d,
                        input logic [6:0] a, input logic [1:0] m, input logic [3:0] t);
    case (sel)
      0: begin
        b32.in_valid = v; b32.in_data = d[31:0]; b32.amt = a[4:0];
        b32.mode = m; b32.tag = t;
      end
      1: begin
        b8.in_valid = v; b8.in_data = d[7:0]; b8.amt = a[2:0];
        b8.mode = m; b8.tag = t[1:0];
      end
      default: begin
        b64.in_valid = v; b64.in_data = d; b64.amt = a[5:0];
        b64.mode = m; b64.tag = t;
      end
    endcase
  endtask

  function automatic logic ovalid(input int sel);
    case (sel)
      0:       ovalid = b32.out_valid;
      1:       ovalid = b8.out_valid;
      default: ovalid = b64.out_valid;
    endcase
  endfunction

  function automatic logic iready(input int sel);
    case (sel)
      0:       iready = b32.in_ready;
      1:       iready = b8.in_ready;
      default: iready = b64.in_ready;
    endcase
  endfunction

  function automatic logic [63:0] odata(input int sel);
    case (sel)
      0:       odata = {32'h0, b32.out_data};
      1:       odata = {56'h0, b8.out_data};
      default: odata = b64.out_data;
    endcase
  endfunction

  function automatic logic [3:0] otag(input int sel);
    case (sel)
      0:       otag = b32.out_tag;
      1:       otag = {2'b00, b8.out_tag};
      default: otag = b64.out_tag;
    endcase
  endfunction

  function automatic logic ozero(input int sel);
    case (sel)
      0:       ozero = b32.out_zero;
      1:       ozero = b8.out_zero;
      default: ozero = b64.out_zero;
    endcase
  endfunction

  // Whole-word reference for the 32-bit instance (single shift, not staged).
  function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] a,
                                        input logic [1:0] m);
    case (m)
      2'b00:   ref32 = d << a;
      2'b01:   ref32 = d >> a;
      2'b10:   ref32 = $signed(d) >>> a;
      default: ref32 = (a == 5'd0) ? d : ((d >> a) | (d << (6'd32 - {1'b0, a})));
    endcase
  endfunction

  // One isolated operation: accept, measure latency, check result, retire it.
  task automatic run_op(input int sel, input string name, input logic [63:0] d,
                        input logic [6:0] a, input logic [1:0] m, input logic [3:0] t,
                        input logic [63:0] exp, input int exp_lat);
    int n;
    set_in(sel, 1'b1, d, a, m, t);
    chk({name, "_in_ready"}, 64'(iready(sel)), 64'd1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 'x, 'x, 2'b00, 4'h0);
    n = 1;
    while (!ovalid(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    $display("op %s: out=%0h tag=%0h latency=%0d", name, odata(sel), otag(sel), n);
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    chk({name, "_data"}, odata(sel), exp);
    chk({name, "_zero"}, 64'(ozero(sel)), 64'(exp == 64'h0));
    chk({name, "_tag"}, 64'(otag(sel)), 64'(t));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] s_data(input int i);
    s_data = 32'h9ABC_DEF0 + 32'(i) * 32'h0001_3579;
  endfunction

  function automatic logic [31:0] bp_data(input int i);
    bp_data = 32'hC000_0001 + 32'(i);
  endfunction

  initial begin
    int sent, recv, first_acc, first_out, last_out, stalls, stale;
    logic acc;
    logic [31:0] e;

    set_in(0, 1'b0, 'x, 'x, 2'b00, 4'h0);
    set_in(1, 1'b0, 'x, 'x, 2'b00, 4'h0);
    set_in(2, 1'b0, 'x, 'x, 2'b00, 4'h0);
    b32.out_ready = 1'b1;
    b8.out_ready  = 1'b1;
    b64.out_ready = 1'b1;

    // Reset state, observed while reset is still asserted.
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_out_data", 64'(b32.out_data), 64'd0);
    chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_out_zero", 64'(b32.out_zero), 64'd1);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_w8_zero", 64'(b8.out_zero), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single operations, WIDTH=32.
    run_op(0, "lsl31", 64'h0000_0001, 7'd31, 2'b00, 4'h1, 64'h8000_0000, 5);
    run_op(0, "lsl1_to_zero", 64'h8000_0000, 7'd1, 2'b00, 4'h2, 64'h0, 5);
    run_op(0, "asr4", 64'h8000_0000, 7'd4, 2'b10, 4'h3, 64'hF800_0000, 5);
    run_op(0, "lsr4", 64'h8000_0000, 7'd4, 2'b01, 4'h4, 64'h0800_0000, 5);
    run_op(0, "ror1", 64'h0000_0001, 7'd1, 2'b11, 4'h5, 64'h8000_0000, 5);
    run_op(0, "ror8", 64'h1234_5678, 7'd8, 2'b11, 4'h6, 64'h7812_3456, 5);
    run_op(0, "asr_amt0", 64'hDEAD_BEEF, 7'd0, 2'b10, 4'h7, 64'hDEAD_BEEF, 5);

    // Streaming: 32 back-to-back operations, downstream always ready.
    sent = 0; recv = 0; first_acc = -1; first_out = -1; last_out = -1; stalls = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent < 32)
        set_in(0, 1'b1, {32'h0, s_data(sent)}, 7'(sent * 7), 2'(sent), 4'(sent));
      else
        set_in(0, 1'b0, 'x, 'x, 2'b00, 4'h0);
      @(negedge clk);
      acc = b32.in_valid && b32.in_ready;
      if (b32.in_valid && !b32.in_ready) stalls++;
      if (acc && first_acc < 0) first_acc = cyc;
      if (b32.out_valid) begin
        if (recv < 32) begin
          e = ref32(s_data(recv), 5'(recv * 7), 2'(recv));
          $display("stream result %0d: out=%h tag=%0h", recv, b32.out_data, b32.out_tag);
          chk($sformatf("stream_data_%0d", recv), 64'(b32.out_data), 64'(e));
          chk($sformatf("stream_tag_%0d", recv), 64'(b32.out_tag), 64'(recv % 16));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        recv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_count", 64'(recv), 64'd32);
    chk("stream_first_latency", 64'(first_out - first_acc), 64'd5);
    chk("stream_contiguous", 64'(last_out - first_out), 64'd31);

    // Backpressure: downstream stalled, upstream always offering.
    b32.out_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      set_in(0, 1'b1, {32'h0, bp_data(sent)}, 7'(sent + 1), 2'b11, 4'(sent + 8));
      @(negedge clk);
      acc = b32.in_valid && b32.in_ready;
      if (b32.out_valid) begin
        chk($sformatf("bp_hold_data_c%0d", cyc), 64'(b32.out_data),
            64'(ref32(bp_data(0), 5'd1, 2'b11)));
        chk($sformatf("bp_hold_tag_c%0d", cyc), 64'(b32.out_tag), 64'd8);
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("bp_accepts", 64'(sent), 64'd5);
    chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
    chk("bp_out_valid_held", 64'(b32.out_valid), 64'd1);

    set_in(0, 1'b0, 'x, 'x, 2'b00, 4'h0);
    b32.out_ready = 1'b1;
    recv = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (b32.out_valid) begin
        if (recv < 5) begin
          $display("drain result %0d: out=%h tag=%0h", recv, b32.out_data, b32.out_tag);
          chk($sformatf("drain_data_%0d", recv), 64'(b32.out_data),
              64'(ref32(bp_data(recv), 5'(recv + 1), 2'b11)));
          chk($sformatf("drain_tag_%0d", recv), 64'(b32.out_tag), 64'(recv + 8));
        end
        recv++;
      end
      @(posedge clk); #1;
    end
    chk("drain_count", 64'(recv), 64'd5);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, 64'(32'h1111_1111 * 32'(i + 1)), 7'd0, 2'b00, 4'(i + 1));
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 'x, 'x, 2'b00, 4'h0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("midrst_out_data", 64'(b32.out_data), 64'd0);
    chk("midrst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("midrst_out_zero", 64'(b32.out_zero), 64'd1);
    chk("midrst_in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (b32.out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    run_op(0, "post_rst_lsl4", 64'h0000_00F1, 7'd4, 2'b00, 4'hA, 64'h0000_0F10, 5);

    // Other widths.
    run_op(1, "w8_ror1", 64'h81, 7'd1, 2'b11, 4'h2, 64'hC0, 3);
    run_op(2, "w64_asr63", 64'h8000_0000_0000_0000, 7'd63, 2'b10, 4'h5,
           64'hFFFF_FFFF_FFFF_FFFF, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
